// File: rtl/sad_argmin_pipe.sv
// Pipelined SAD arg-min: a registered binary compare tree reduces each batch of
// candidate SADs to (min, index). A running accumulator after the root then tracks
// the best (SAD, x, y) across the rows of a block.
module sad_argmin_pipe #(
    parameter int SAD_W  = 18,
    parameter int N_CAND = 16,
    parameter int ROW_W  = 4,
    localparam int IDX_W = $clog2(N_CAND)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [N_CAND*SAD_W-1:0]   in_sad,
    output logic                      out_valid,
    output logic [SAD_W-1:0]          out_sad,
    output logic [IDX_W-1:0]          out_mv_x,
    output logic [ROW_W-1:0]          out_mv_y,
    output logic                      out_ovf
);

    localparam int LAT = IDX_W + 1;
    localparam logic [ROW_W-1:0] RowMax = {ROW_W{1'b1}};

    // Row counter / block tracking at the input
    logic             open_q;
    logic [ROW_W-1:0] row_q, row_d;
    logic             ovf_q, ovf_d;
    logic             eff_first;

    // Tags travelling alongside the tree levels, one entry per level
    logic [LAT-2:0]   tv_q, tf_q, tl_q, tovf_q;
    logic [ROW_W-1:0] trow_q [LAT-1];

    // A batch arriving with no open block starts one at row 0
    always_comb begin
        eff_first = in_first | ~open_q;
        row_d     = '0;
        ovf_d     = 1'b0;
        if (!eff_first) begin
            row_d = (row_q == RowMax) ? row_q : row_q + ROW_W'(1);
            ovf_d = ovf_q | (row_q == RowMax);
        end
    end

    // Row counter, overflow flag and open-block state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= 1'b0;
            row_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (in_valid) begin
            open_q <= ~in_last;
            row_q  <= row_d;
            ovf_q  <= ovf_d;
        end
    end

    // Tag shift register, one stage per tree level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv_q   <= '0;
            tf_q   <= '0;
            tl_q   <= '0;
            tovf_q <= '0;
            for (int k = 0; k < LAT - 1; k++) trow_q[k] <= '0;
        end else begin
            for (int k = 0; k < LAT - 1; k++) begin
                if (k == 0) begin
                    tv_q[0]   <= in_valid;
                    tf_q[0]   <= eff_first;
                    tl_q[0]   <= in_last;
                    tovf_q[0] <= ovf_d;
                    trow_q[0] <= row_d;
                end else begin
                    tv_q[k]   <= tv_q[k-1];
                    tf_q[k]   <= tf_q[k-1];
                    tl_q[k]   <= tl_q[k-1];
                    tovf_q[k] <= tovf_q[k-1];
                    trow_q[k] <= trow_q[k-1];
                end
            end
        end
    end

    // Compare tree: level l holds N_CAND >> (l+1) nodes
    for (genvar l = 0; l < IDX_W; l++) begin : g_lvl
        localparam int NN = N_CAND >> (l + 1);
        logic [SAD_W-1:0] sad_q [NN];
        logic [SAD_W-1:0] sad_d [NN];
        logic [IDX_W-1:0] idx_q [NN];
        logic [IDX_W-1:0] idx_d [NN];

        if (l == 0) begin : g_leaf
            // Pairwise compare of raw candidates; b wins only if strictly smaller
            always_comb begin
                for (int j = 0; j < NN; j++) begin
                    sad_d[j] = in_sad[2*j*SAD_W +: SAD_W];
                    idx_d[j] = '0;
                    if (in_sad[(2*j+1)*SAD_W +: SAD_W] < in_sad[2*j*SAD_W +: SAD_W]) begin
                        sad_d[j] = in_sad[(2*j+1)*SAD_W +: SAD_W];
                        idx_d[j] = IDX_W'(1);
                    end
                end
            end
        end else begin : g_node
            // Compare child nodes; the winner's index gains bit l
            always_comb begin
                for (int j = 0; j < NN; j++) begin
                    sad_d[j] = g_lvl[l-1].sad_q[2*j];
                    idx_d[j] = g_lvl[l-1].idx_q[2*j];
                    if (g_lvl[l-1].sad_q[2*j+1] < g_lvl[l-1].sad_q[2*j]) begin
                        sad_d[j] = g_lvl[l-1].sad_q[2*j+1];
                        idx_d[j] = g_lvl[l-1].idx_q[2*j+1] | (IDX_W'(1) << l);
                    end
                end
            end
        end

        // Level register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < NN; j++) begin
                    sad_q[j] <= '0;
                    idx_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < NN; j++) begin
                    sad_q[j] <= sad_d[j];
                    idx_q[j] <= idx_d[j];
                end
            end
        end
    end

    logic [SAD_W-1:0] root_sad;
    logic [IDX_W-1:0] root_idx;
    assign root_sad = g_lvl[IDX_W-1].sad_q[0];
    assign root_idx = g_lvl[IDX_W-1].idx_q[0];

    // Accumulator state
    logic [SAD_W-1:0] acc_sad_q, acc_sad_d;
    logic [IDX_W-1:0] acc_x_q, acc_x_d;
    logic [ROW_W-1:0] acc_y_q, acc_y_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             done_q, done_d;

    // First row loads; later rows replace only when strictly smaller (earlier row wins ties)
    always_comb begin
        acc_sad_d = acc_sad_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        acc_ovf_d = acc_ovf_q;
        done_d    = tv_q[LAT-2] & tl_q[LAT-2];
        if (tv_q[LAT-2]) begin
            acc_ovf_d = tovf_q[LAT-2];
            if (tf_q[LAT-2] || (root_sad < acc_sad_q)) begin
                acc_sad_d = root_sad;
                acc_x_d   = root_idx;
                acc_y_d   = trow_q[LAT-2];
            end
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sad_q <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            acc_ovf_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_sad_q <= acc_sad_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            acc_ovf_q <= acc_ovf_d;
            done_q    <= done_d;
        end
    end

    // Result register: pulse valid, hold values until the next block completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_mv_x  <= '0;
            out_mv_y  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= done_q;
            if (done_q) begin
                out_sad  <= acc_sad_q;
                out_mv_x <= acc_x_q;
                out_mv_y <= acc_y_q;
                out_ovf  <= acc_ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_sad_argmin_pipe.sv
// Directed and randomized bench for sad_argmin_pipe against a block-level model.
module tb_sad_argmin_pipe;

    localparam int SAD_W  = 18;
    localparam int N_CAND = 16;
    localparam int ROW_W  = 2;
    localparam int IDX_W  = 4;
    localparam int LAT    = IDX_W + 1;
    localparam int YMAX   = (1 << ROW_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_first = 1'b0;
    logic                    in_last = 1'b0;
    logic [N_CAND*SAD_W-1:0] in_sad = '0;
    logic                    out_valid;
    logic [SAD_W-1:0]        out_sad;
    logic [IDX_W-1:0]        out_mv_x;
    logic [ROW_W-1:0]        out_mv_y;
    logic                    out_ovf;

    sad_argmin_pipe #(
        .SAD_W (SAD_W),
        .N_CAND(N_CAND),
        .ROW_W (ROW_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .in_sad   (in_sad),
        .out_valid(out_valid),
        .out_sad  (out_sad),
        .out_mv_x (out_mv_x),
        .out_mv_y (out_mv_y),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] x;
        logic [ROW_W-1:0] y;
        logic             ovf;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Values the outputs are expected to hold
    logic [SAD_W-1:0] h_sad = '0;
    logic [IDX_W-1:0] h_x = '0;
    logic [ROW_W-1:0] h_y = '0;
    logic             h_ovf = 1'b0;

    // Block-level model state
    bit               m_open = 0;
    int               m_rows = 0;
    logic [SAD_W-1:0] m_best;
    int               m_x, m_y;

    logic [N_CAND*SAD_W-1:0] vec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    // Advance one clock and compare against the expected pulse/hold state
    task automatic tick();
        bit   exp_v;
        res_t r;
        @(posedge clk);
        #1;
        cycle++;
        exp_v = (q.size() != 0) && (q[0].due == cycle);
        check("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            r     = q.pop_front();
            h_sad = r.sad;
            h_x   = r.x;
            h_y   = r.y;
            h_ovf = r.ovf;
        end
        check("out_sad", 64'(out_sad), 64'(h_sad));
        check("out_mv_x", 64'(out_mv_x), 64'(h_x));
        check("out_mv_y", 64'(out_mv_y), 64'(h_y));
        check("out_ovf", 64'(out_ovf), 64'(h_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_first = 1'($urandom);
            in_last  = 1'($urandom);
            in_sad   = {N_CAND{18'($urandom)}};
            tick();
        end
    endtask

    // Drive one batch and update the model from the block rules
    task automatic send(input bit f, input bit l);
        logic [SAD_W-1:0] bmin;
        int               bidx;
        bit               start;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_sad   = vec;
        start = f || !m_open;
        if (start) m_rows = 0;
        else m_rows++;
        bmin = vec[0 +: SAD_W];
        bidx = 0;
        for (int i = 1; i < N_CAND; i++) begin
            if (vec[i*SAD_W +: SAD_W] < bmin) begin
                bmin = vec[i*SAD_W +: SAD_W];
                bidx = i;
            end
        end
        if (start || bmin < m_best) begin
            m_best = bmin;
            m_x    = bidx;
            m_y    = (m_rows > YMAX) ? YMAX : m_rows;
        end
        if (l) begin
            q.push_back('{due: cycle + 1 + LAT, sad: m_best, x: IDX_W'(m_x),
                          y: ROW_W'(m_y), ovf: (m_rows > YMAX)});
            m_open = 0;
        end else begin
            m_open = 1;
        end
        tick();
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < N_CAND; i++) vec[i*SAD_W +: SAD_W] = SAD_W'(v);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < N_CAND; i++) vec[i*SAD_W +: SAD_W] = SAD_W'($urandom_range(hi, lo));
    endtask

    task automatic set_cand(input int i, input int v);
        vec[i*SAD_W +: SAD_W] = SAD_W'(v);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        q.delete();
        h_sad = '0;
        h_x   = '0;
        h_y   = '0;
        h_ovf = 1'b0;
        m_open = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        do_reset();
        idle(2);

        // 1: single row, sad_i = 100 - i
        for (int i = 0; i < N_CAND; i++) set_cand(i, 100 - i);
        send(1, 1);
        idle(LAT + 2);
        check("t1_const", 64'({out_sad, out_mv_x, out_mv_y}), 64'({18'd85, 4'd15, 2'd0}));

        // 2: ties within a row and across rows
        fill_const(50); set_cand(3, 7); set_cand(9, 7);
        send(1, 1);
        idle(LAT + 1);
        check("t2_tie_x", 64'(out_mv_x), 64'd3);
        fill_const(50); set_cand(6, 7); send(1, 0);
        fill_const(50); send(0, 0);
        fill_const(50); set_cand(2, 7); send(0, 1);
        idle(LAT + 1);
        check("t2_tie_y", 64'({out_mv_x, out_mv_y}), 64'({4'd6, 2'd0}));

        // 3: four rows back-to-back, then an immediate second block
        for (int r = 0; r < 4; r++) begin
            fill_rand(20, 5000);
            if (r == 2) set_cand(5, 12);
            send(r == 0, r == 3);
        end
        fill_rand(0, 3000); send(1, 0);
        fill_rand(0, 3000); send(0, 1);
        idle(LAT + 2);

        // 4: overflow with saturated row, then a clean block
        for (int r = 0; r < 6; r++) begin
            fill_rand(100, 9000);
            if (r == 5) set_cand(9, 3);
            send(r == 0, r == 5);
        end
        idle(LAT + 1);
        check("t4_ovf", 64'({out_ovf, out_mv_y, out_mv_x}), 64'({1'b1, 2'd3, 4'd9}));
        fill_rand(0, 9000); send(1, 0);
        fill_rand(0, 9000); send(0, 1);
        idle(LAT + 1);
        check("t4_noovf", 64'(out_ovf), 64'd0);

        // 5: abort a block with a fresh in_first
        for (int r = 0; r < 3; r++) begin
            fill_rand(500, 9000); set_cand(r, 1);
            send(r == 0, 0);
        end
        fill_rand(200, 9000); send(1, 0);
        fill_rand(200, 9000); send(0, 1);
        idle(LAT + 2);

        // 6: reset two cycles after a last row; then a block without in_first
        fill_rand(0, 9000); send(1, 0);
        fill_rand(0, 9000); send(0, 1);
        idle(1);
        do_reset();
        idle(LAT + 1);
        fill_rand(0, 9000); send(0, 0);
        fill_rand(0, 9000); send(0, 1);
        idle(LAT + 1);

        // Randomized blocks with gaps, aborts and narrow value ranges for ties
        for (int b = 0; b < 30; b++) begin
            int nrows;
            bit narrow;
            nrows  = $urandom_range(6, 1);
            narrow = ($urandom_range(3, 0) == 0);
            for (int r = 0; r < nrows; r++) begin
                if (narrow) fill_rand(0, 3);
                else fill_rand(0, (1 << SAD_W) - 1);
                send((r == 0) ? ($urandom_range(3, 0) != 0) : ($urandom_range(9, 0) == 0),
                     r == nrows - 1);
                if ($urandom_range(2, 0) == 0) idle($urandom_range(2, 1));
            end
        end
        idle(LAT + 4);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
